// File: rtl/adder_4_bist.sv
// Exhaustive built-in self-test for a WIDTH-bit adder: sweeps every (op_a, op_b) pair and
// checks the returned sum. Optional macro STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module adder_4_bist #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH:0]     sum_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic               fail_valid
);
    localparam int EW = 2*WIDTH + 1;
    // SETTLE_CYCLES is limited to 1..15 so the settle counter fits in four bits.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0]  fail_a_q, fail_a_d, fail_b_q, fail_b_d;
    logic              fail_valid_q, fail_valid_d;
    logic [EW-1:0]     err_q, err_d;
    logic [3:0]        settle_q, settle_d;
    logic [WIDTH:0]    golden;
    logic              mismatch;
    logic              last_vec;

    assign golden   = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign mismatch = (golden != sum_in);
    assign last_vec = (&op_a_q) && (&op_b_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_valid_q <= 1'b0;
            err_q        <= '0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_valid_q <= fail_valid_d;
            err_q        <= err_d;
            settle_q     <= settle_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_valid_d = fail_valid_q;
        err_d        = err_q;
        settle_d     = settle_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_DRIVE;
                    op_a_d       = '0;
                    op_b_d       = '0;
                    fail_a_d     = '0;
                    fail_b_d     = '0;
                    fail_valid_d = 1'b0;
                    err_d        = '0;
                    settle_d     = '0;
                end
            end
            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = S_CHECK;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + EW'(1);
                    if (!fail_valid_q) begin
                        fail_a_d     = op_a_q;
                        fail_b_d     = op_b_q;
                        fail_valid_d = 1'b1;
                    end
                end
`ifdef STOP_ON_FAIL_EN
                if (mismatch || last_vec) begin
`else
                if (last_vec) begin
`endif
                    state_d = S_DONE;
                end else begin
                    // op_b runs fastest; op_a steps when op_b wraps.
                    state_d = S_DRIVE;
                    op_b_d  = op_b_q + WIDTH'(1);
                    if (&op_b_q) begin
                        op_a_d = op_a_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign busy       = (state_q == S_DRIVE) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;
    assign fail_valid = fail_valid_q;
endmodule

// File: tb/tb_adder_4_bist.sv
// Scoreboard bench for adder_4_bist: a behavioural adder with selectable faults feeds sum_in,
// expected sweep results are queued at start and checked when done rises.
module tb_adder_4_bist;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op_a, op_b, fail_a, fail_b;
    logic [4:0] sum_in;
    logic       busy, done, pass, fail_valid;
    logic [8:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;   // 0 = correct adder, 1 = sum bit0 stuck-at-0, 2 = sum forced 0 at (15,15)

    typedef struct {
        int err;
        int pss;
        int fv;
        int fa;
        int fb;
        int oa;
        int ob;
        int cycles;
    } exp_t;
    exp_t exp_q[$];

    adder_4_bist #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .sum_in(sum_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_a(fail_a), .fail_b(fail_b), .fail_valid(fail_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        sum_in = {1'b0, op_a} + {1'b0, op_b};
        if (mode == 1) sum_in[0] = 1'b0;
        if (mode == 2 && op_a == 4'd15 && op_b == 4'd15) sum_in = 5'd0;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles and scores each completed sweep against the queue head.
    logic done_prev = 1'b0;
    logic busy_prev = 1'b0;
    int   busy_cnt  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy && !busy_prev) busy_cnt = 1;
        else if (busy) busy_cnt++;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sweep_cycles", busy_cnt, e.cycles);
                check("err_count", int'(err_count), e.err);
                check("pass", int'(pass), e.pss);
                check("fail_valid", int'(fail_valid), e.fv);
                check("fail_a", int'(fail_a), e.fa);
                check("fail_b", int'(fail_b), e.fb);
                check("op_a_hold", int'(op_a), e.oa);
                check("op_b_hold", int'(op_b), e.ob);
                check("busy_in_done", int'(busy), 0);
            end
        end
        done_prev = done;
        busy_prev = busy;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_timeout", int'(done), 1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_op_a"}, int'(op_a), 0);
        check({tag, "_op_b"}, int'(op_b), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_fail_a"}, int'(fail_a), 0);
        check({tag, "_fail_b"}, int'(fail_b), 0);
        check({tag, "_fail_valid"}, int'(fail_valid), 0);
    endtask

    function automatic exp_t mk(int err, int pss, int fv, int fa, int fb, int oa, int ob, int cyc);
        exp_t e;
        e.err = err; e.pss = pss; e.fv = fv; e.fa = fa; e.fb = fb;
        e.oa = oa; e.ob = ob; e.cycles = cyc;
        return e;
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        // Clean sweep with a correct adder.
        mode = 0;
        exp_q.push_back(mk(0, 1, 0, 0, 0, 15, 15, 512));
        pulse_start();
        wait_done();

        // Sum bit0 stuck at 0: every odd sum (128 of 256) mismatches, first at (0,1).
        mode = 1;
`ifdef STOP_ON_FAIL_EN
        exp_q.push_back(mk(1, 0, 1, 0, 1, 0, 1, 4));
`else
        exp_q.push_back(mk(128, 0, 1, 0, 1, 15, 15, 512));
`endif
        pulse_start();
        wait_done();

        // Only the final vector is corrupted; restart from DONE must clear prior results.
        mode = 2;
        exp_q.push_back(mk(1, 0, 1, 15, 15, 15, 15, 512));
        pulse_start();
        wait_done();

        // A start pulse mid-sweep is ignored.
        mode = 0;
        exp_q.push_back(mk(0, 1, 0, 0, 0, 15, 15, 512));
        pulse_start();
        repeat (48) @(negedge clk);
        pulse_start();
        wait_done();

        // Reset mid-sweep with errors already accumulated.
        mode = 1;
        pulse_start();
        repeat (99) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("midrst");

        // Fresh full sweep after the reset.
        mode = 0;
        exp_q.push_back(mk(0, 1, 0, 0, 0, 15, 15, 512));
        pulse_start();
        wait_done();

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
